// File: rtl/ysyx_ifu_if.sv
// Fetch-unit bundle: instruction memory request/response,
// decoder handoff and execute-side redirect/halt.
interface ysyx_ifu_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        do_jump;
    logic [31:0] jump_target;
    logic        halt;

    modport master (
        output imem_req_valid, imem_addr,
        output inst_valid, inst, pc,
        input  imem_req_ready, imem_rsp_valid, imem_rdata,
        input  inst_ready, do_jump, jump_target, halt
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        input  inst_valid, inst, pc,
        output imem_req_ready, imem_rsp_valid, imem_rdata,
        output inst_ready, do_jump, jump_target, halt
    );
endinterface

// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: one fetch in flight, holds the word
// until the decoder takes it; redirects drop stale responses.
module ysyx_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input logic        clk,
    input logic        rst,
    ysyx_ifu_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        halted_q, halted_d;
    logic        req_valid_q, req_valid_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] tgt;

    assign tgt = {bus.jump_target[31:2], 2'b00};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        halted_d = halted_q;
        unique case (state_q)
            S_REQ: begin
                if (!halted_q) begin
                    // An accepted request that is redirected still
                    // owes us a response, which must be thrown away.
                    if (bus.do_jump)
                        state_d = bus.imem_req_ready ? S_DROP : S_REQ;
                    else if (bus.imem_req_ready)
                        state_d = S_WAIT;
                    if (bus.halt)
                        halted_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (bus.do_jump) begin
                        state_d = S_REQ;
                    end else begin
                        inst_d  = bus.imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (bus.do_jump) begin
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (bus.do_jump) begin
                    state_d = S_REQ;
                end else if (bus.inst_ready) begin
                    state_d = S_REQ;
                    pc_d    = pc_q + 32'd4;
                end
                if (bus.inst_ready && bus.halt)
                    halted_d = 1'b1;
            end
            S_DROP: begin
                if (bus.imem_rsp_valid)
                    state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        if (bus.do_jump)
            pc_d = tgt;
        req_valid_d  = (state_d == S_REQ) && !halted_d;
        inst_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            halted_q     <= 1'b0;
            req_valid_q  <= 1'b1;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            halted_q     <= halted_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_addr      = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.pc             = pc_q;

endmodule
